ps2_kbd_rx: RTL and testbench

// - Device-side receiver for the PS/2 keyboard stream driven by the MiST I/O controller (ps2_kbd_clk/ps2_kbd_data).
// - Filters the lines, deserialises 11-bit frames and checks parity.
// - Folds the E0/F0 prefixes into one key event and buffers events in a small FIFO for an on-chip consumer (keyboard matrix mapper, OSD hotkeys).

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 35 +++
 rtl/ps2_kbd_rx.sv | 155 +++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a stability filter: the output only
// follows the synchronised line after it has held a new level for FILTER_LEN cycles.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic line_in,
  output logic line_out
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync     <= '1;
      cnt      <= '0;
      line_out <= 1'b1;
    end else begin
      sync <= {sync[0], line_in};
      if (sync[1] == line_out) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        line_out <= sync[1];
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filtered lines, 11-bit frame FSM with parity check,
// E0/F0 prefix folding and a small key-event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 43000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  input  logic       ev_rd,
  output logic       err_parity,
  output logic       err_overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_f, data_f, clk_f_d, strobe;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .line_in  (ps2_clk),
    .line_out (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .line_in  (ps2_data),
    .line_out (data_f)
  );

  assign strobe = clk_f_d & ~clk_f;

  ps2_rx_state_t state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] idle_cnt;
  logic          pfx_ext, pfx_rel;
  logic          ev_wr;
  ps2_event_t    ev_wdata;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      idle_cnt   <= '0;
      pfx_ext    <= 1'b0;
      pfx_rel    <= 1'b0;
      ev_wr      <= 1'b0;
      ev_wdata   <= '0;
      err_parity <= 1'b0;
      clk_f_d    <= 1'b1;
    end else begin
      clk_f_d    <= clk_f;
      ev_wr      <= 1'b0;
      err_parity <= 1'b0;
      // A stalled frame is silently abandoned; prefix flags are kept.
      if (state != IDLE && !strobe && idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state    <= IDLE;
        idle_cnt <= '0;
      end else begin
        if (state == IDLE || strobe)
          idle_cnt <= '0;
        else
          idle_cnt <= idle_cnt + TW'(1);
        if (strobe) begin
          case (state)
            IDLE: begin
              if (!data_f) begin
                state  <= DATA;
                bitcnt <= '0;
              end
            end
            DATA: begin
              shreg  <= {data_f, shreg[7:1]};
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7)
                state <= PARITY;
            end
            PARITY: begin
              par_bit <= data_f;
              state   <= STOP;
            end
            STOP: begin
              if ((^{shreg, par_bit}) && data_f) begin
                if (shreg == PS2_PFX_EXT) begin
                  pfx_ext <= 1'b1;
                end else if (shreg == PS2_PFX_REL) begin
                  pfx_rel <= 1'b1;
                end else begin
                  ev_wr    <= 1'b1;
                  ev_wdata <= '{ext: pfx_ext, rel: pfx_rel, code: shreg};
                  pfx_ext  <= 1'b0;
                  pfx_rel  <= 1'b0;
                end
              end else begin
                err_parity <= 1'b1;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  ps2_event_t    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, pop, push;
  ps2_event_t    head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ev_rd & ~empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign push  = ev_wr & (~full | pop);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= ev_wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign ev_valid     = ~empty;
  assign ev_code      = head.code;
  assign ev_ext       = head.ext;
  assign ev_rel       = head.rel;
  assign err_overflow = ev_wr & full & ~pop;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx using a shortened timeout and PS/2 bit period.
module tb_ps2_kbd_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 400;
  localparam int unsigned HALF = 40;

  logic       clk_sys = 1'b0;
  logic       reset_n, ps2_clk, ps2_data, ev_rd;
  logic       ev_valid, ev_ext, ev_rel, err_parity, err_overflow;
  logic [7:0] ev_code;

  int unsigned total = 0, bad = 0;
  int unsigned par_cnt = 0, ovf_cnt = 0;
  int unsigned p0, o0;

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .ev_valid     (ev_valid),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_rel       (ev_rel),
    .ev_rd        (ev_rd),
    .err_parity   (err_parity),
    .err_overflow (err_overflow)
  );

  always @(posedge clk_sys) begin
    if (err_parity)   par_cnt++;
    if (err_overflow) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic p;
    p = (~^b) ^ flip_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    idle(HALF);
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_code"}, ev_code, code);
    chk({tag, "_ext"}, ev_ext, ext);
    chk({tag, "_rel"}, ev_rel, rel);
    ev_rd = 1'b1;
    @(negedge clk_sys);
    ev_rd = 1'b0;
  endtask

  initial begin
    logic [7:0] codes [5];
    logic [7:0] b;
    codes = '{8'h15, 8'h16, 8'h1D, 8'h24, 8'h2D};

    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ev_rd = 1'b0;
    idle(4);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", ev_code, 0);
    chk("rst_ext", ev_ext, 0);
    chk("rst_rel", ev_rel, 0);
    chk("rst_perr", err_parity, 0);
    chk("rst_ovf", err_overflow, 0);
    reset_n = 1'b1;
    idle(4);

    // 0x1C with the final falling edge timed: 2 sync + 8 filter + 2 pipeline edges.
    b = 8'h1C;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    idle(HALF);
    ps2_clk = 1'b0;
    repeat (11) @(posedge clk_sys);
    #1 chk("lat_pre", ev_valid, 0);
    @(posedge clk_sys);
    #1 chk("lat_rise", ev_valid, 1);
    @(negedge clk_sys);
    idle(HALF);
    ps2_clk = 1'b1;
    idle(HALF);
    expect_ev("ev1c", 8'h1C, 1'b0, 1'b0);
    chk("ev1c_empty", ev_valid, 0);

    send_frame(8'hE0, 1'b0);
    chk("pfx_e0_none", ev_valid, 0);
    send_frame(8'hF0, 1'b0);
    chk("pfx_f0_none", ev_valid, 0);
    send_frame(8'h75, 1'b0);
    expect_ev("ev75", 8'h75, 1'b1, 1'b1);
    chk("ev75_empty", ev_valid, 0);
    send_frame(8'h1C, 1'b0);
    expect_ev("ev1c_b", 8'h1C, 1'b0, 1'b0);

    p0 = par_cnt;
    send_frame(8'h1C, 1'b1);
    chk("perr_pulse", par_cnt - p0, 1);
    chk("perr_noev", ev_valid, 0);
    send_frame(8'h1C, 1'b0);
    expect_ev("ev1c_c", 8'h1C, 1'b0, 1'b0);
    chk("perr_once", par_cnt - p0, 1);

    send_frame(8'hE0, 1'b0);
    send_frame(8'h33, 1'b1);
    send_frame(8'h75, 1'b0);
    expect_ev("ev75_keep", 8'h75, 1'b1, 1'b0);

    o0 = ovf_cnt;
    foreach (codes[i]) send_frame(codes[i], 1'b0);
    chk("ovf_pulse", ovf_cnt - o0, 1);
    for (int i = 0; i < 4; i++) expect_ev($sformatf("fifo%0d", i), codes[i], 1'b0, 1'b0);
    chk("fifo_empty", ev_valid, 0);

    p0 = par_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2_data = 1'b1;
    idle(TO + 100);
    chk("to_noev", ev_valid, 0);
    chk("to_noerr", par_cnt - p0, 0);
    send_frame(8'h29, 1'b0);
    expect_ev("ev29", 8'h29, 1'b0, 1'b0);

    p0 = par_cnt;
    ps2_data = 1'b0;
    idle(10);
    ps2_clk = 1'b0;
    idle(FL - 2);
    ps2_clk = 1'b1;
    idle(20);
    ps2_data = 1'b1;
    idle(20);
    send_frame(8'h1C, 1'b0);
    expect_ev("glitch_1c", 8'h1C, 1'b0, 1'b0);
    chk("glitch_noerr", par_cnt - p0, 0);

    send_frame(8'h1C, 1'b0);
    send_frame(8'hE0, 1'b0);
    chk("prerst_valid", ev_valid, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("mrst_valid", ev_valid, 0);
    chk("mrst_code", ev_code, 0);
    chk("mrst_ext", ev_ext, 0);
    chk("mrst_rel", ev_rel, 0);
    chk("mrst_perr", err_parity, 0);
    reset_n = 1'b1;
    ps2_data = 1'b1;
    idle(20);
    send_frame(8'h29, 1'b0);
    expect_ev("post_rst", 8'h29, 1'b0, 1'b0);
    chk("post_rst_empty", ev_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
